// File: rtl/stream_mux_rr.sv
// N-channel, W-bit stream multiplexer with one registered output stage.
// Channel choice is either an external select or round-robin among requesters.
module stream_mux_rr #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  // Handshake: a word moves across any port on a rising edge where its valid
  // and ready are both high; valid never waits on ready, ready may follow valid.

  logic             load;
  logic             fix_hit;
  logic             rr_hit;
  logic             grant_valid;
  logic [SEL_W-1:0] rr_idx;
  logic [SEL_W-1:0] rr_try;
  logic [SEL_W-1:0] grant;
  logic [WIDTH-1:0] grant_data;
  logic [SEL_W-1:0] ptr;

  assign load = !out_valid || out_ready;

  // Comparing against every legal index means an out-of-range sel never hits.
  always_comb begin
    fix_hit = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (sel == SEL_W'(i) && in_valid[i]) fix_hit = 1'b1;
    end
  end

  always_comb begin
    rr_hit = 1'b0;
    rr_idx = '0;
    rr_try = '0;
    for (int k = 1; k <= CHANNELS; k++) begin
      rr_try = SEL_W'((int'(ptr) + k) % CHANNELS);
      if (!rr_hit && in_valid[rr_try]) begin
        rr_hit = 1'b1;
        rr_idx = rr_try;
      end
    end
  end

  assign grant       = mode ? rr_idx : sel;
  assign grant_valid = rst_n && load && (mode ? rr_hit : fix_hit);

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant == SEL_W'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = grant_valid && (grant == SEL_W'(i));
    end
  end

  // ptr resets to the last channel so that channel 0 wins the first search.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      ptr       <= SEL_W'(CHANNELS - 1);
    end else if (load) begin
      if (grant_valid) begin
        out_data  <= grant_data;
        out_chan  <= grant;
        out_valid <= 1'b1;
        if (mode) ptr <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel and a 3-channel instance,
// expected words queued by the driver and popped by per-instance monitors.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;

  logic        mode;
  logic [1:0]  sel;
  logic [31:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic        out_valid;
  logic        out_ready;

  logic        mode3;
  logic [1:0]  sel3;
  logic [23:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic [7:0]  out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  logic [9:0]  exp_q[$];
  logic [9:0]  exp_q3[$];

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [31:0] DATA_A = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
  localparam logic [23:0] DATA_B = {8'hB2, 8'hB1, 8'hB0};

  stream_mux_rr #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  stream_mux_rr #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode3), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_chan(out_chan3), .out_valid(out_valid3),
    .out_ready(out_ready3)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word4_unexpected: got %0h expected none", {out_chan, out_data});
      end else begin
        check("word4", {22'd0, out_chan, out_data}, {22'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid3 && out_ready3) begin
      if (exp_q3.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL word3_unexpected: got %0h expected none", {out_chan3, out_data3});
      end else begin
        check("word3", {22'd0, out_chan3, out_data3}, {22'd0, exp_q3.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b1;
    mode = 1'b0; sel = 2'd2; in_data = DATA_A; in_valid = 4'hF; out_ready = 1'b1;
    mode3 = 1'b0; sel3 = 2'd0; in_data3 = DATA_B; in_valid3 = 3'b000; out_ready3 = 1'b1;
    #2 rst_n = 1'b0;
    cycle();
    cycle();

    // reset state, with every channel requesting
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_out_chan",  32'(out_chan),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    check("rst_out_valid3", 32'(out_valid3), 32'd0);
    in_valid = 4'h0;
    rst_n = 1'b1;
    #1;

    // 1: fixed select of channel 2
    mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({2'd2, 8'hA2});
      #1;
      check("fix_in_ready", 32'(in_ready), 32'b0100);
      cycle();
    end
    in_valid = 4'h0;
    cycle();

    // 2: round-robin saturated; ptr still at reset value so ch0 goes first
    mode = 1'b1; in_valid = 4'hF;
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    exp_q.push_back({2'd2, 8'hA2});
    exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd0, 8'hA0});
    exp_q.push_back({2'd1, 8'hA1});
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("rr_sat_out_valid", 32'(out_valid), 32'd1);
    end

    // 3: sparse requests after a ch1 grant, then drain
    in_valid = 4'b1010;
    exp_q.push_back({2'd3, 8'hA3});
    exp_q.push_back({2'd1, 8'hA1});
    cycle();
    cycle();
    in_valid = 4'b0000;
    cycle();
    check("drain_out_valid", 32'(out_valid), 32'd0);
    check("drain_out_data",  32'(out_data),  32'hA1);
    check("drain_out_chan",  32'(out_chan),  32'd1);

    // 4: backpressure holding 0x5A from ch1
    in_data = {8'hA3, 8'hA2, 8'h5A, 8'hA0};
    in_valid = 4'b0010;
    exp_q.push_back({2'd1, 8'h5A});
    cycle();
    out_ready = 1'b0;
    in_valid = 4'b0110;
    #1;
    check("bp_in_ready_first", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("bp_out_data",  32'(out_data),  32'h5A);
      check("bp_out_chan",  32'(out_chan),  32'd1);
      check("bp_in_ready",  32'(in_ready),  32'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 32'(in_ready), 32'b0100);
    exp_q.push_back({2'd2, 8'hA2});
    cycle();
    in_valid = 4'h0;
    in_data = DATA_A;
    cycle();

    // 5: three channels; out-of-range select, then switch to round-robin
    mode3 = 1'b1; in_valid3 = 3'b001;
    exp_q3.push_back({2'd0, 8'hB0});
    cycle();
    in_valid3 = 3'b000;
    cycle();
    mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    #1;
    check("oor_in_ready", 32'(in_ready3), 32'd0);
    cycle();
    check("oor_out_valid", 32'(out_valid3), 32'd0);
    sel3 = 2'd2;
    #1;
    check("fix3_in_ready", 32'(in_ready3), 32'b100);
    exp_q3.push_back({2'd2, 8'hB2});
    cycle();
    mode3 = 1'b1;
    #1;
    check("switch_in_ready", 32'(in_ready3), 32'b010);
    exp_q3.push_back({2'd1, 8'hB1});
    cycle();
    in_valid3 = 3'b000;
    cycle();

    // 6: asynchronous reset between edges while a word is held
    mode = 1'b1; in_valid = 4'hF;
    exp_q.push_back({2'd3, 8'hA3});
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_out_data",  32'(out_data),  32'd0);
    check("arst_out_chan",  32'(out_chan),  32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd0);
    exp_q.delete();
    cycle();
    rst_n = 1'b1;
    exp_q.push_back({2'd0, 8'hA0});
    cycle();
    check("post_rst_chan",  32'(out_chan),  32'd0);
    check("post_rst_valid", 32'(out_valid), 32'd1);
    in_valid = 4'h0;
    cycle();
    cycle();

    check("exp_q_empty",  32'(exp_q.size()),  32'd0);
    check("exp_q3_empty", 32'(exp_q3.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
# stream_mux_rr

Parametrised N-channel, W-bit stream multiplexer with a registered output and valid/ready handshakes on every port. It replaces the fixed 4-to-1 single-bit combinational select in datapaths that need flow control. It supports two modes: an externally driven channel select, or fair round-robin arbitration among the requesting channels. It sits between several producer blocks and one shared consumer.

## Interface
- WIDTH, 8, data bits per channel (≥1)
- CHANNELS, 4, number of input channels (2..16); SEL_W = clog2(CHANNELS) is derived internally and is not overridable
- clk  input  1  rising-edge clock, the only clock
- rst_n  input  1  asynchronous, active-low reset
- mode  input  1  0 = fixed select via sel, 1 = round-robin
- sel  input  SEL_W  channel index used when mode=0
- in_data  input  CHANNELS*WIDTH  packed inputs; channel i occupies [i*WIDTH +: WIDTH]
- in_valid  input  CHANNELS  per-channel valid
- in_ready  output  CHANNELS  per-channel ready; at most one bit is high
- out_data  output  WIDTH  registered data
- out_chan  output  SEL_W  index of the channel that supplied out_data
- out_valid  output  1  registered valid
- out_ready  input  1  consumer ready

## Operation
- The block has a single output register stage and no skid buffer.
- `load = !out_valid || out_ready`.
- Grant selection (combinational) happens only while load=1:
  - mode=0: grant = sel if sel < CHANNELS and in_valid[sel]=1; otherwise no grant. An out-of-range sel never grants.
  - mode=1: grant = the first channel with in_valid=1, searching upward from (ptr+1) mod CHANNELS and wrapping. No valid channels means no grant.
- in_ready[g] = 1 only for the granted g. All bits are 0 when load=0, when there is no grant, or while rst_n=0.
- A transfer occurs when in_valid[g] && in_ready[g] on a clock edge:
  - out_data ← in_data[g]
  - out_chan ← g
  - out_valid ← 1
- If load=1 and there is no grant: out_valid ← 0. out_data and out_chan hold their last values.
- If out_valid=1 and out_ready=0: out_data, out_chan and out_valid hold, and no channel is granted.
- Round-robin pointer ptr (SEL_W bits):
  - Reset value is CHANNELS-1, so channel 0 has first priority.
  - It updates to g on every transfer made while mode=1.
  - Transfers made while mode=0 do not change it.
- A mode change takes effect at the next grant evaluation. ptr is retained across the change.
- in_valid deasserting without a transfer is tolerated; grant is simply re-evaluated every cycle.

## Timing
- Latency: input transfer at edge k → out_valid=1 with the data visible after edge k (one cycle).
- Throughput: one word per cycle while out_ready=1 and some channel is granted.
- Back-to-back case: out_valid=1 with out_ready=1 pops the current word and loads a new one on the same edge.
- Reset: when rst_n falls, immediately (no clock needed):
  - out_valid=0, out_data=0, out_chan=0, ptr=CHANNELS-1
  - in_ready=0 while rst_n=0
- A word held in the output register is discarded when reset is asserted mid-stream.
- Reset release: the first grant can occur on the first clock edge with rst_n=1.
- No combinational path from out_ready to out_valid or out_data. in_ready depends combinationally on out_ready, out_valid, in_valid, mode, sel and ptr.

## Test plan
1. **Fixed select.** WIDTH=8, CHANNELS=4, mode=0, sel=2, in_data={A3,A2,A1,A0}, in_valid=1111, out_ready=1 → in_ready=0100 every cycle; out_data=A2 and out_chan=2 one cycle later; ptr stays 3.
2. **Round-robin saturated.** mode=1, in_valid=1111 held, out_ready=1 → out_chan sequence 0,1,2,3,0,1 on consecutive cycles with out_valid continuously 1.
3. **Round-robin sparse with wrap.** mode=1, in_valid=1010, previous grant=1 → next grants are 3 then 1. Then in_valid=0000 → out_valid drops to 0 one cycle after the last pop, and out_data holds.
4. **Backpressure.** With out_valid=1 carrying 0x5A from ch1, drive out_ready=0 for 3 cycles → out_data=0x5A and out_chan=1 are stable, in_ready=0000, ptr is unchanged. Then out_ready=1 → in the same cycle in_ready grants ch2, and the next word appears one cycle later.
5. **Out-of-range select and mode switch.** CHANNELS=3, mode=0, sel=3, in_valid=111 → in_ready=000 and out_valid=0. Then mode=1 → grants resume from the ptr held before the switch.
6. **Async reset mid-stream.** During round-robin traffic, pull rst_n low between clock edges → out_valid=0, out_data=0, out_chan=0 and in_ready=0 immediately. After release with in_valid=1111 → first out_chan=0.
